// File: rtl/add4_bist_pkg.sv
// Shared types for the add4 self-test engine: FSM state encoding and error-counter width.
package add4_bist_pkg;

    localparam int ERRCNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_CHECK,
        S_PASS,
        S_FAIL
    } state_t;

endpackage

// File: rtl/add4_bist_if.sv
// Operand/sum and status bundle between the self-test engine and its consumer.
// err_cnt exists only when ADD4_BIST_ERRCNT_EN is defined.
interface add4_bist_if
    import add4_bist_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] err_a;
    logic [WIDTH-1:0] err_b;
    logic [WIDTH:0]   err_s;
`ifdef ADD4_BIST_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    modport master (
        input  start, s,
        output a, b, busy, done, pass, err_a, err_b, err_s
`ifdef ADD4_BIST_ERRCNT_EN
        , output err_cnt
`endif
    );

    modport slave (
        output start, s,
        input  a, b, busy, done, pass, err_a, err_b, err_s
`ifdef ADD4_BIST_ERRCNT_EN
        , input err_cnt
`endif
    );

endinterface

// File: rtl/add4.sv
// 4-bit adder exercised by the self-test engine; the carry lands in s[WIDTH].
module add4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s
);

    assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add4_bist_vecgen.sv
// Operand sweep generator: {b,a} counter with a is the low half, plus the settle-wait counter.
module add4_bist_vecgen #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             hold,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last,
    output logic             settled
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [2*WIDTH-1:0] VEC_ONE  = 1;
    localparam logic [WAIT_W-1:0]  WAIT_ONE = 1;

    logic [2*WIDTH-1:0] vec_q, vec_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    assign a       = vec_q[WIDTH-1:0];
    assign b       = vec_q[2*WIDTH-1:WIDTH];
    assign last    = &vec_q;
    assign settled = (wait_q == WAIT_W'(SETTLE - 1));

    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        if (clr) begin
            vec_d  = '0;
            wait_d = '0;
        end else if (step) begin
            vec_d  = vec_q + VEC_ONE;
            wait_d = '0;
        end else if (hold && !settled) begin
            // Stop counting once settled so the counter never wraps if HOLD lingers.
            wait_d = wait_q + WAIT_ONE;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            vec_q  <= '0;
            wait_q <= '0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/add4_bist.sv
// Self-test engine for add4: sweeps every {b,a}, checks s == a + b, reports pass/fail.
// Define ADD4_BIST_ERRCNT_EN to run the full sweep and count mismatches instead of stopping.
module add4_bist
    import add4_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input logic         ck,
    input logic         rst,
    add4_bist_if.master bus
);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] err_a_q, err_a_d;
    logic [WIDTH-1:0] err_b_q, err_b_d;
    logic [WIDTH:0]   err_s_q, err_s_d;
`ifdef ADD4_BIST_ERRCNT_EN
    localparam logic [ERRCNT_W-1:0] CNT_ONE = 1;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    logic             clr, step, hold, last, settled, mismatch;
    logic [WIDTH-1:0] a_w, b_w;
    logic [WIDTH:0]   sum_exp;

    add4_bist_vecgen #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_vecgen (
        .ck      (ck),
        .rst     (rst),
        .clr     (clr),
        .step    (step),
        .hold    (hold),
        .a       (a_w),
        .b       (b_w),
        .last    (last),
        .settled (settled)
    );

    // Full WIDTH+1 comparison so a broken carry-out is caught too.
    assign sum_exp  = {1'b0, a_w} + {1'b0, b_w};
    assign mismatch = (bus.s != sum_exp);
    assign hold     = (state_q == S_HOLD);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_a_d = err_a_q;
        err_b_d = err_b_q;
        err_s_d = err_s_q;
        clr     = 1'b0;
        step    = 1'b0;
`ifdef ADD4_BIST_ERRCNT_EN
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (bus.start) begin
                    state_d = S_HOLD;
                    clr     = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_a_d = '0;
                    err_b_d = '0;
                    err_s_d = '0;
`ifdef ADD4_BIST_ERRCNT_EN
                    err_cnt_d = '0;
`endif
                end
            end
            S_HOLD: begin
                if (settled) state_d = S_CHECK;
            end
            S_CHECK: begin
`ifdef ADD4_BIST_ERRCNT_EN
                if (mismatch) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
                    // Count is zero only before the first mismatch (it saturates, never wraps).
                    if (err_cnt_q == '0) begin
                        err_a_d = a_w;
                        err_b_d = b_w;
                        err_s_d = bus.s;
                    end
                end
                if (last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                    state_d = pass_d ? S_PASS : S_FAIL;
                end else begin
                    step    = 1'b1;
                    state_d = S_HOLD;
                end
`else
                if (mismatch) begin
                    err_a_d = a_w;
                    err_b_d = b_w;
                    err_s_d = bus.s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_FAIL;
                end else if (last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    state_d = S_PASS;
                end else begin
                    step    = 1'b1;
                    state_d = S_HOLD;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_a_q <= '0;
            err_b_q <= '0;
            err_s_q <= '0;
`ifdef ADD4_BIST_ERRCNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            err_s_q <= err_s_d;
`ifdef ADD4_BIST_ERRCNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign bus.a     = a_w;
    assign bus.b     = b_w;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.pass  = pass_q;
    assign bus.err_a = err_a_q;
    assign bus.err_b = err_b_q;
    assign bus.err_s = err_s_q;
`ifdef ADD4_BIST_ERRCNT_EN
    assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_add4_bist.sv
// Scoreboard bench for add4_bist driving a real add4 with an optional s[0] stuck-at-0 fault.
module tb_add4_bist;
    import add4_bist_pkg::*;

    localparam int W     = 4;
    localparam int SWEEP = 512;

    typedef struct {
        int         tag;
        int         start_cyc;
        int         lat;
        logic       pass;
        logic [W-1:0] a, b, ea, eb;
        logic [W:0] es;
        int         cnt;
    } exp_t;

    logic       ck = 1'b0;
    logic       rst;
    logic       fault;
    logic [W:0] s_raw;
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    exp_t       sb[$];

    add4_bist_if #(.WIDTH(W)) bus();

    add4 #(.WIDTH(W)) u_add (.a(bus.a), .b(bus.b), .s(s_raw));

    assign bus.s = fault ? {s_raw[W:1], 1'b0} : s_raw;

    add4_bist #(.WIDTH(W), .SETTLE(1)) dut (.ck(ck), .rst(rst), .bus(bus));

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_a"},     int'(bus.a),     0);
        chk({pfx, "_b"},     int'(bus.b),     0);
        chk({pfx, "_busy"},  int'(bus.busy),  0);
        chk({pfx, "_done"},  int'(bus.done),  0);
        chk({pfx, "_pass"},  int'(bus.pass),  0);
        chk({pfx, "_err_a"}, int'(bus.err_a), 0);
        chk({pfx, "_err_b"}, int'(bus.err_b), 0);
        chk({pfx, "_err_s"}, int'(bus.err_s), 0);
`ifdef ADD4_BIST_ERRCNT_EN
        chk({pfx, "_err_cnt"}, int'(bus.err_cnt), 0);
`endif
    endtask

    // One-clock start pulse; returns the cycle number of the edge that sampled it.
    task automatic pulse_start(output int sc);
        @(negedge ck);
        bus.start = 1'b1;
        @(negedge ck);
        bus.start = 1'b0;
        sc = cyc;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("done_after_start", int'(bus.done), 0);
    endtask

    task automatic push_good(input int tag, input int sc);
        exp_t e;
        e.tag = tag; e.start_cyc = sc; e.lat = SWEEP; e.pass = 1'b1;
        e.a = 4'hf; e.b = 4'hf; e.ea = '0; e.eb = '0; e.es = '0; e.cnt = 0;
        sb.push_back(e);
    endtask

    task automatic push_stuck0(input int tag, input int sc);
        exp_t e;
        e.tag = tag; e.start_cyc = sc; e.pass = 1'b0;
        e.ea = 4'h1; e.eb = 4'h0; e.es = 5'h00;
`ifdef ADD4_BIST_ERRCNT_EN
        e.lat = SWEEP; e.a = 4'hf; e.b = 4'hf; e.cnt = 128;
`else
        e.lat = 4; e.a = 4'h1; e.b = 4'h0; e.cnt = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge ck);
        chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each rising edge of done.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge ck);
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d: done after %0d clk pass=%0b a=%h b=%h err_a=%h err_b=%h err_s=%h",
                             e.tag, cyc - e.start_cyc, bus.pass, bus.a, bus.b,
                             bus.err_a, bus.err_b, bus.err_s);
                    chk("latency", cyc - e.start_cyc, e.lat);
                    chk("pass",    int'(bus.pass),  int'(e.pass));
                    chk("busy",    int'(bus.busy),  0);
                    chk("a_final", int'(bus.a),     int'(e.a));
                    chk("b_final", int'(bus.b),     int'(e.b));
                    chk("err_a",   int'(bus.err_a), int'(e.ea));
                    chk("err_b",   int'(bus.err_b), int'(e.eb));
                    chk("err_s",   int'(bus.err_s), int'(e.es));
`ifdef ADD4_BIST_ERRCNT_EN
                    chk("err_cnt", int'(bus.err_cnt), e.cnt);
`endif
                end
            end
            done_prev = bus.done;
        end
    end

    initial begin
        int sc;
        rst       = 1'b1;
        bus.start = 1'b0;
        fault     = 1'b0;

        // Reset held 3 clocks with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            bus.start = 1'($urandom);
            fault     = 1'($urandom);
        end
        @(negedge ck);
        chk_zero("reset");
        rst       = 1'b0;
        bus.start = 1'b0;
        fault     = 1'b0;
        $display("txn reset: outputs checked after 3-clock reset");

        // Good adder, full sweep.
        pulse_start(sc);
        push_good(1, sc);
        drain(SWEEP + 20);

        // s[0] stuck-at-0.
        fault = 1'b1;
        pulse_start(sc);
        push_stuck0(2, sc);
        drain(SWEEP + 20);
        fault = 1'b0;

        // Restart from the finished state; second start at clock 100 must be ignored.
        pulse_start(sc);
        push_good(3, sc);
        repeat (99) @(negedge ck);
        bus.start = 1'b1;
        @(negedge ck);
        bus.start = 1'b0;
        chk("busy_mid_sweep", int'(bus.busy), 1);
        drain(SWEEP + 20);

        // Reset at clock 200 of a sweep aborts it.
        pulse_start(sc);
        repeat (199) @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk_zero("midrst");
        $display("txn 4: sweep aborted by reset at clock 200");
        repeat (5) @(negedge ck);
        chk("done_after_abort", int'(bus.done), 0);

        // Full pass after the abort.
        pulse_start(sc);
        push_good(5, sc);
        drain(SWEEP + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
